// File: rtl/sampler_pkg.sv
// Shared types and constants for the assignment sampler.
// State encoding, LFSR constants and the Galois step function.
package sampler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_CHECK,
    S_EMIT,
    S_END
  } state_t;

  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/sampler_lfsr.sv
// 32-bit Galois LFSR with synchronous load and advance.
// nxt is the value the register takes on an advance.
module sampler_lfsr
  import sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        advance,
  output logic [31:0] state,
  output logic [31:0] nxt
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    nxt    = lfsr_step(lfsr_q);
    lfsr_d = lfsr_q;
    if (load)
      lfsr_d = load_val;
    else if (advance)
      lfsr_d = nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= LFSR_RESET;
    else
      lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/assignment_sampler.sv
// Random candidate generator: writes candidates, streams a satisfying one.
// Optional SAMPLER_STATS_EN adds a saturating CHECK counter (tries_used).
module assignment_sampler
  import sampler_pkg::*;
#(
  parameter  int NUM_VARS  = 8,
  parameter  int VAL_W     = 16,
  parameter  int MAX_TRIES = 1024,
  localparam int IDX_W     = $clog2(NUM_VARS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  output logic             cand_wr,
  output logic [IDX_W-1:0] cand_idx,
  output logic [VAL_W-1:0] cand_val,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [VAL_W-1:0] out_val,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             fail
`ifdef SAMPLER_STATS_EN
  ,
  output logic [31:0]      tries_used
`endif
);

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_VARS - 1);
  localparam logic [31:0]      TRIES = 32'(MAX_TRIES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      tries_q, tries_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             lfsr_load, lfsr_adv;
  logic [31:0]      lfsr_state, lfsr_nxt, load_val;
  logic [VAL_W-1:0] buf_q [NUM_VARS];

  assign load_val = (seed == 32'h0) ? LFSR_RESET : seed;

  sampler_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (load_val),
    .advance  (lfsr_adv),
    .state    (lfsr_state),
    .nxt      (lfsr_nxt)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_GEN;
          lfsr_load = 1'b1;
          tries_d   = 32'h0;
          idx_d     = '0;
        end
      end
      S_GEN: begin
        lfsr_adv = 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_CHECK;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_CHECK: begin
        if (sat) begin
          state_d = S_EMIT;
          idx_d   = '0;
        end else begin
          tries_d = tries_q + 32'd1;
          if (tries_d >= TRIES) begin
            state_d = S_END;
            fail_d  = 1'b1;
          end else begin
            state_d = S_GEN;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            state_d = S_END;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tries_q <= 32'h0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tries_q <= tries_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  // Candidate storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (state_q == S_GEN)
      buf_q[idx_q] <= lfsr_nxt[VAL_W-1:0];
  end

  always_comb begin
    cand_wr   = (state_q == S_GEN);
    cand_idx  = cand_wr ? idx_q : '0;
    cand_val  = cand_wr ? lfsr_nxt[VAL_W-1:0] : '0;
    out_valid = (state_q == S_EMIT);
    out_idx   = out_valid ? idx_q : '0;
    out_val   = out_valid ? buf_q[idx_q] : '0;
    out_last  = out_valid && (idx_q == LAST);
    busy      = (state_q != S_IDLE);
    done      = done_q;
    fail      = fail_q;
  end

`ifdef SAMPLER_STATS_EN
  logic [31:0] stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (state_q == S_CHECK && stats_q != 32'hFFFF_FFFF)
      stats_d = stats_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stats_q <= 32'h0;
    else
      stats_q <= stats_d;
  end

  assign tries_used = stats_q;
`endif

endmodule
